// File: rtl/noc_host_scheduler.sv
// Host-side scheduler for the 3x3 ALU NoC: round-robin arbitration, one packet in flight.
// Optional WAIT-state timeout is enabled by defining NOC_SCHED_TIMEOUT_EN.
module noc_host_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [64*NUM_REQ-1:0]   req_a,
  input  logic [64*NUM_REQ-1:0]   req_b,
  input  logic [4*NUM_REQ-1:0]    req_mode,
  input  logic [2*NUM_REQ-1:0]    req_dst_x,
  input  logic [2*NUM_REQ-1:0]    req_dst_y,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [63:0]             resp_data,
  output logic                    resp_err,
  output logic [63:0]             host_in_a,
  output logic [63:0]             host_in_b,
  output logic [15:0]             host_in_ctrl,
  output logic                    host_in_valid,
  input  logic [63:0]             host_out_a,
  input  logic                    host_out_valid,
  output logic                    busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("noc_host_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  // ERR is a one-cycle bubble standing in for INJECT when the destination is off-grid.
  typedef enum logic [2:0] {
    S_IDLE,
    S_INJECT,
    S_WAIT,
    S_ERR,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic [63:0]          host_in_a_q, host_in_a_d;
  logic [63:0]          host_in_b_q, host_in_b_d;
  logic [15:0]          host_in_ctrl_q, host_in_ctrl_d;
  logic                 host_in_valid_q, host_in_valid_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [63:0]          resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;
  logic                 busy_q, busy_d;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     cand_idx;
  int                   cand;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic [63:0]          win_a;
  logic [63:0]          win_b;
  logic [3:0]           win_mode;
  logic [1:0]           win_dst_x;
  logic [1:0]           win_dst_y;
  logic                 accept;
  logic                 dst_ok;
  logic                 wait_expired;

`ifdef NOC_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign wait_cnt_d   = (state_q == S_WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
  assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wait_expired = 1'b0;
`endif

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[PTR_W-1:0];
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    win_onehot   = '0;
    grant_onehot = '0;
    win_a        = '0;
    win_b        = '0;
    win_mode     = '0;
    win_dst_x    = '0;
    win_dst_y    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_onehot[i] = (grant_q == PTR_W'(i));
      if (win_idx == PTR_W'(i)) begin
        win_onehot[i] = 1'b1;
        win_a         = req_a[64*i +: 64];
        win_b         = req_b[64*i +: 64];
        win_mode      = req_mode[4*i +: 4];
        win_dst_x     = req_dst_x[2*i +: 2];
        win_dst_y     = req_dst_y[2*i +: 2];
      end
    end
  end

  assign accept    = (state_q == S_IDLE) && win_found;
  assign req_ready = accept ? win_onehot : '0;
  assign dst_ok    = (win_dst_x <= 2'd2) && (win_dst_y <= 2'd2);

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    host_in_a_d     = '0;
    host_in_b_d     = '0;
    host_in_ctrl_d  = '0;
    host_in_valid_d = 1'b0;
    resp_data_d     = '0;
    resp_err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          grant_d = win_idx;
          if (dst_ok) begin
            state_d         = S_INJECT;
            host_in_a_d     = win_a;
            host_in_b_d     = win_b;
            host_in_ctrl_d  = {7'd0, 1'b0, win_dst_x, win_dst_y, win_mode};
            host_in_valid_d = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      // The NoC is combinational, so the reply may already be present while injecting.
      S_INJECT: begin
        if (host_out_valid) begin
          state_d     = S_RESP;
          resp_data_d = host_out_a;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (host_out_valid) begin
          state_d     = S_RESP;
          resp_data_d = host_out_a;
        end else if (wait_expired) begin
          state_d    = S_RESP;
          resp_err_d = 1'b1;
        end
      end
      S_ERR: begin
        state_d    = S_RESP;
        resp_err_d = 1'b1;
      end
      S_RESP: begin
        state_d  = S_IDLE;
        rr_ptr_d = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    resp_valid_d = (state_d == S_RESP) ? grant_onehot : '0;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      grant_q         <= '0;
      host_in_a_q     <= '0;
      host_in_b_q     <= '0;
      host_in_ctrl_q  <= '0;
      host_in_valid_q <= 1'b0;
      resp_valid_q    <= '0;
      resp_data_q     <= '0;
      resp_err_q      <= 1'b0;
      busy_q          <= 1'b0;
`ifdef NOC_SCHED_TIMEOUT_EN
      wait_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_q         <= grant_d;
      host_in_a_q     <= host_in_a_d;
      host_in_b_q     <= host_in_b_d;
      host_in_ctrl_q  <= host_in_ctrl_d;
      host_in_valid_q <= host_in_valid_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_err_q      <= resp_err_d;
      busy_q          <= busy_d;
`ifdef NOC_SCHED_TIMEOUT_EN
      wait_cnt_q      <= wait_cnt_d;
`endif
    end
  end

  assign host_in_a     = host_in_a_q;
  assign host_in_b     = host_in_b_q;
  assign host_in_ctrl  = host_in_ctrl_q;
  assign host_in_valid = host_in_valid_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_err      = resp_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_noc_host_scheduler.sv
// Directed self-checking bench for noc_host_scheduler; the bench plays the tile(0,0) ALU.
module tb_noc_host_scheduler;

  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [64*NUM_REQ-1:0]  req_a;
  logic [64*NUM_REQ-1:0]  req_b;
  logic [4*NUM_REQ-1:0]   req_mode;
  logic [2*NUM_REQ-1:0]   req_dst_x;
  logic [2*NUM_REQ-1:0]   req_dst_y;
  logic [NUM_REQ-1:0]     resp_valid;
  logic [63:0]            resp_data;
  logic                   resp_err;
  logic [63:0]            host_in_a;
  logic [63:0]            host_in_b;
  logic [15:0]            host_in_ctrl;
  logic                   host_in_valid;
  logic [63:0]            host_out_a;
  logic                   host_out_valid;
  logic                   busy;

  int errors = 0;
  int checks = 0;

  logic [63:0] cap_a;
  logic [63:0] cap_b;
  logic [3:0]  cap_mode;

  noc_host_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_mode       (req_mode),
    .req_dst_x      (req_dst_x),
    .req_dst_y      (req_dst_y),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .host_in_a      (host_in_a),
    .host_in_b      (host_in_b),
    .host_in_ctrl   (host_in_ctrl),
    .host_in_valid  (host_in_valid),
    .host_out_a     (host_out_a),
    .host_out_valid (host_out_valid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] mode);
    case (mode)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] mode, input logic [1:0] dx, input logic [1:0] dy);
    req_a[64*i +: 64]   = a;
    req_b[64*i +: 64]   = b;
    req_mode[4*i +: 4]  = mode;
    req_dst_x[2*i +: 2] = dx;
    req_dst_y[2*i +: 2] = dy;
  endtask

  task automatic capture_inject();
    cap_a    = host_in_a;
    cap_b    = host_in_b;
    cap_mode = host_in_ctrl[3:0];
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    req_valid      = '0;
    host_out_valid = 1'b0;
    host_out_a     = '0;
    #2;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n          = 1'b1;
    req_valid      = '0;
    req_a          = '0;
    req_b          = '0;
    req_mode       = '0;
    req_dst_x      = '0;
    req_dst_y      = '0;
    host_out_a     = '0;
    host_out_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b want 0000", resp_valid); end
    checks++; if (host_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_host_in_valid: got %b want 0", host_in_valid); end
    checks++; if (host_in_ctrl !== 16'h0000) begin errors++; $display("[TB] FAIL reset_host_in_ctrl: got %h want 0000", host_in_ctrl); end
    checks++; if (resp_data !== 64'd0 || resp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp: got data=%h err=%b want 0/0", resp_data, resp_err); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready: got %b want 0000", req_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Scenario 1: single request, tile answers one cycle after the inject strobe.
  task automatic test_single();
    set_req(0, 64'd5, 64'd3, 4'd0, 2'd1, 2'd1);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    capture_inject();
    checks++; if (host_in_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_inject: got %b want 1", host_in_valid); end
    checks++; if (host_in_ctrl !== 16'h0050) begin errors++; $display("[TB] FAIL single_ctrl: got %h want 0050", host_in_ctrl); end
    checks++; if (host_in_a !== 64'd5 || host_in_b !== 64'd3) begin errors++; $display("[TB] FAIL single_operands: got a=%0d b=%0d want 5/3", host_in_a, host_in_b); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
    tick();
    checks++; if (host_in_valid !== 1'b0 || host_in_a !== 64'd0) begin errors++; $display("[TB] FAIL single_inject_clear: got v=%b a=%h want 0/0", host_in_valid, host_in_a); end
    host_out_a     = alu_model(cap_a, cap_b, cap_mode);
    host_out_valid = 1'b1;
    tick();
    host_out_valid = 1'b0;
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL single_resp_valid: got %b want 0001", resp_valid); end
    checks++; if (resp_data !== 64'd8 || resp_err !== 1'b0) begin errors++; $display("[TB] FAIL single_resp: got data=%0d err=%b want 8/0", resp_data, resp_err); end
    tick();
    checks++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_done: got rv=%b busy=%b want 0000/0", resp_valid, busy); end
  endtask

  // Scenario 2: Req1 and Req2 valid out of reset, served in round-robin order.
  task automatic test_round_robin();
    logic [3:0] exp_oh;
    rst_n = 1'b0;
    #2;
    set_req(1, 64'd6, 64'd7, 4'd2, 2'd2, 2'd2);
    set_req(2, 64'd6, 64'd7, 4'd2, 2'd2, 2'd2);
    req_valid = 4'b0110;
    tick();
    rst_n = 1'b1;
    #1;
    for (int g = 1; g <= 2; g++) begin
      exp_oh = 4'b0001 << g;
      checks++; if (req_ready !== exp_oh) begin errors++; $display("[TB] FAIL rr_ready_%0d: got %b want %b", g, req_ready, exp_oh); end
      tick();
      req_valid[g] = 1'b0;
      capture_inject();
      checks++; if (host_in_ctrl !== 16'h00A2) begin errors++; $display("[TB] FAIL rr_ctrl_%0d: got %h want 00a2", g, host_in_ctrl); end
      tick();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rr_ready_wait_%0d: got %b want 0000", g, req_ready); end
      host_out_a     = alu_model(cap_a, cap_b, cap_mode);
      host_out_valid = 1'b1;
      tick();
      host_out_valid = 1'b0;
      checks++; if (resp_valid !== exp_oh || resp_data !== 64'd42) begin errors++; $display("[TB] FAIL rr_resp_%0d: got rv=%b data=%0d want %b/42", g, resp_valid, resp_data, exp_oh); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rr_ready_resp_%0d: got %b want 0000", g, req_ready); end
      tick();
    end
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL rr_ptr_end: got %b want 1000", req_ready); end
    req_valid = '0;
    #1;
  endtask

  // Scenario 3: off-grid destination skips injection and returns an error.
  task automatic test_bad_dst();
    set_req(0, 64'd1, 64'd1, 4'd0, 2'd3, 2'd0);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL baddst_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (host_in_valid !== 1'b0 || resp_valid !== 4'b0000 || busy !== 1'b1) begin errors++; $display("[TB] FAIL baddst_cycle1: got hv=%b rv=%b busy=%b want 0/0000/1", host_in_valid, resp_valid, busy); end
    tick();
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL baddst_resp_valid: got %b want 0001", resp_valid); end
    checks++; if (resp_err !== 1'b1 || resp_data !== 64'd0 || host_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL baddst_resp: got err=%b data=%h hv=%b want 1/0/0", resp_err, resp_data, host_in_valid); end
    tick();
    checks++; if (resp_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL baddst_done: got err=%b busy=%b want 0/0", resp_err, busy); end
  endtask

  // Scenario 4: reply arrives in the inject cycle; spurious strobes in RESP/IDLE are ignored.
  task automatic test_same_cycle();
    set_req(3, 64'd9, 64'd4, 4'd1, 2'd0, 2'd1);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL same_ready: got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    capture_inject();
    checks++; if (host_in_ctrl !== 16'h0011) begin errors++; $display("[TB] FAIL same_ctrl: got %h want 0011", host_in_ctrl); end
    host_out_a     = alu_model(cap_a, cap_b, cap_mode);
    host_out_valid = 1'b1;
    tick();
    host_out_a = 64'd99;
    checks++; if (resp_valid !== 4'b1000 || resp_data !== 64'd5 || resp_err !== 1'b0) begin errors++; $display("[TB] FAIL same_resp: got rv=%b data=%0d err=%b want 1000/5/0", resp_valid, resp_data, resp_err); end
    tick();
    checks++; if (busy !== 1'b0 || resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL spurious_resp: got busy=%b rv=%b want 0/0000", busy, resp_valid); end
    tick();
    checks++; if (busy !== 1'b0 || resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL spurious_idle: got busy=%b rv=%b want 0/0000", busy, resp_valid); end
    host_out_valid = 1'b0;
    host_out_a     = '0;
  endtask

  // Scenario 5: tile never answers.
  task automatic test_timeout();
    int bad_cycles;
    bad_cycles = 0;
    set_req(0, 64'd1, 64'd2, 4'd0, 2'd0, 2'd0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    checks++; if (host_in_valid !== 1'b1) begin errors++; $display("[TB] FAIL timeout_inject: got %b want 1", host_in_valid); end
    tick();
`ifdef NOC_SCHED_TIMEOUT_EN
    repeat (TIMEOUT_CYCLES - 1) begin
      tick();
      if (resp_valid !== 4'b0000 || busy !== 1'b1) bad_cycles++;
    end
    checks++; if (bad_cycles !== 0) begin errors++; $display("[TB] FAIL timeout_early: got %0d bad cycles want 0", bad_cycles); end
    tick();
    checks++; if (resp_valid !== 4'b0001 || resp_err !== 1'b1 || resp_data !== 64'd0) begin errors++; $display("[TB] FAIL timeout_resp: got rv=%b err=%b data=%h want 0001/1/0", resp_valid, resp_err, resp_data); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_done: got busy=%b want 0", busy); end
`else
    repeat (100) begin
      tick();
      if (busy !== 1'b1 || resp_valid !== 4'b0000) bad_cycles++;
    end
    checks++; if (bad_cycles !== 0) begin errors++; $display("[TB] FAIL wait_hold: got %0d bad cycles want 0", bad_cycles); end
`endif
  endtask

  // Scenario 6: asynchronous reset during WAIT aborts the transaction.
  task automatic test_reset_abort();
    do_reset();
    set_req(2, 64'd3, 64'd3, 4'd0, 2'd1, 2'd0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_wait_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || host_in_valid !== 1'b0 || resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL abort_async: got busy=%b hv=%b rv=%b want 0/0/0000", busy, host_in_valid, resp_valid); end
    tick();
    rst_n          = 1'b1;
    host_out_a     = 64'd6;
    host_out_valid = 1'b1;
    tick();
    checks++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_late1: got rv=%b busy=%b want 0000/0", resp_valid, busy); end
    tick();
    checks++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_late2: got rv=%b busy=%b want 0000/0", resp_valid, busy); end
    host_out_valid = 1'b0;
    req_valid      = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL abort_ready: got %b want 0001", req_ready); end
    req_valid = '0;
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bad_dst();
    test_same_cycle();
    test_timeout();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
